// File: rtl/regfile_access_ctrl.sv
// Register-file front end: dual-source reads, in-order write-back buffer,
// read-side forwarding, and drain of buffered writes through RAM port A.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iRdValid,
    output logic                  oRdReady,
    input  logic [ADDR_WIDTH-1:0] iRsAddr,
    input  logic [ADDR_WIDTH-1:0] iRtAddr,
    output logic                  oRdValid,
    output logic [DATA_WIDTH-1:0] oRsData,
    output logic [DATA_WIDTH-1:0] oRtData,
    input  logic                  iWbValid,
    input  logic [ADDR_WIDTH-1:0] iWbAddr,
    input  logic [DATA_WIDTH-1:0] iWbData,
    output logic                  oBusy,
    output logic [ADDR_WIDTH-1:0] oRamAddrA,
    output logic [DATA_WIDTH-1:0] oRamDataA,
    output logic                  oRamEnA,
    output logic                  oRamWeA,
    output logic [ADDR_WIDTH-1:0] oRamAddrB,
    output logic [DATA_WIDTH-1:0] oRamDataB,
    output logic                  oRamEnB,
    output logic                  oRamWeB,
    input  logic [DATA_WIDTH-1:0] iRamDataA,
    input  logic [DATA_WIDTH-1:0] iRamDataB
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
    logic [ADDR_WIDTH-1:0] wb_addr_d [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_d [WB_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  rd_valid_q, rd_valid_d;
    logic                  rs_hit_q, rs_hit_d;
    logic                  rt_hit_q, rt_hit_d;
    logic                  rs_zero_q, rs_zero_d;
    logic                  rt_zero_q, rt_zero_d;
    logic [DATA_WIDTH-1:0] rs_fwd_q, rs_fwd_d;
    logic [DATA_WIDTH-1:0] rt_fwd_q, rt_fwd_d;

    logic                  rd_ready;
    logic                  rd_acc;
    logic                  drain;
    logic                  enq;

    // Reset gates both RAM accesses so discarded writes never reach the RAM.
    always_comb begin
        rd_ready = count_q < CW'(WB_DEPTH - 1);
        rd_acc   = iRdValid && rd_ready && !iRst;
        drain    = !rd_acc && (count_q != '0) && !iRst;
        enq      = iWbValid && (iWbAddr != '0);
    end

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            wb_addr_d[wr_ptr_q] = iWbAddr;
            wb_data_d[wr_ptr_q] = iWbData;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (enq && !drain) begin
            count_d = count_q + CW'(1);
        end else if (!enq && drain) begin
            count_d = count_q - CW'(1);
        end
    end

    // Walk oldest to youngest so the last match wins; same-cycle write beats all.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        rs_hit_d  = 1'b0;
        rt_hit_d  = 1'b0;
        rs_fwd_d  = '0;
        rt_fwd_d  = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (wb_addr_q[idx] == iRsAddr) begin
                    rs_hit_d = 1'b1;
                    rs_fwd_d = wb_data_q[idx];
                end
                if (wb_addr_q[idx] == iRtAddr) begin
                    rt_hit_d = 1'b1;
                    rt_fwd_d = wb_data_q[idx];
                end
            end
        end
        if (enq && (iWbAddr == iRsAddr)) begin
            rs_hit_d = 1'b1;
            rs_fwd_d = iWbData;
        end
        if (enq && (iWbAddr == iRtAddr)) begin
            rt_hit_d = 1'b1;
            rt_fwd_d = iWbData;
        end
        rs_zero_d  = (iRsAddr == '0);
        rt_zero_d  = (iRtAddr == '0);
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge iClk) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
        if (iRst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rs_hit_q   <= 1'b0;
            rt_hit_q   <= 1'b0;
            rs_zero_q  <= 1'b0;
            rt_zero_q  <= 1'b0;
            rs_fwd_q   <= '0;
            rt_fwd_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rs_hit_q   <= rs_hit_d;
            rt_hit_q   <= rt_hit_d;
            rs_zero_q  <= rs_zero_d;
            rt_zero_q  <= rt_zero_d;
            rs_fwd_q   <= rs_fwd_d;
            rt_fwd_q   <= rt_fwd_d;
        end
    end

    always_comb begin
        oRdReady  = rd_ready;
        oRdValid  = rd_valid_q;
        oBusy     = (count_q != '0);
        oRsData   = (!rd_valid_q || rs_zero_q) ? '0 :
                    (rs_hit_q ? rs_fwd_q : iRamDataA);
        oRtData   = (!rd_valid_q || rt_zero_q) ? '0 :
                    (rt_hit_q ? rt_fwd_q : iRamDataB);
        oRamEnA   = rd_acc || drain;
        oRamWeA   = drain;
        oRamAddrA = rd_acc ? iRsAddr :
                    (drain ? wb_addr_q[rd_ptr_q] : '0);
        oRamDataA = drain ? wb_data_q[rd_ptr_q] : '0;
        oRamEnB   = rd_acc;
        oRamWeB   = 1'b0;
        oRamAddrB = rd_acc ? iRtAddr : '0;
        oRamDataB = '0;
    end

endmodule
